math_op_arbiter: RTL and testbench

Two-requester front end that shares one `math_operators` datapath (add, subtract, multiply) between independent clients. Each client presents an operation and operands with a valid/ready handshake. The block grants one request per cycle with round-robin fairness, drives the shared datapath, and registers the selected result with the requester's ID into a single-entry output stage with backpressure. It sits between client FSMs and the combinational arithmetic unit.

---
 rtl/math_op_pkg.sv | 18 +
 rtl/math_operators.sv | 26 ++
 rtl/math_op_arbiter.sv | 130 +++++++++++++
 tb/tb_math_op_arbiter.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/math_op_pkg.sv
// Shared types for the math_op_arbiter slice.
//   op_t         : operation code carried by each request
//   slot_state_t : occupancy of the single-entry response register
package math_op_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_MUL = 2'b10,
    OP_RSV = 2'b11
  } op_t;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } slot_state_t;

endpackage

// File: rtl/math_operators.sv
// Combinational arithmetic unit shared by all requesters.
//   a, b : unsigned operands, WIDTH bits
//   s    : a + b  mod 2^WIDTH
//   d    : a - b  mod 2^WIDTH
//   p    : full unsigned product, 2*WIDTH bits
module math_operators #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [WIDTH-1:0]   s,
  output logic [WIDTH-1:0]   d,
  output logic [2*WIDTH-1:0] p
);

  logic [2*WIDTH-1:0] a_ext;
  logic [2*WIDTH-1:0] b_ext;

  assign a_ext = {{WIDTH{1'b0}}, a};
  assign b_ext = {{WIDTH{1'b0}}, b};

  assign s = a + b;
  assign d = a - b;
  assign p = a_ext * b_ext;

endmodule

// File: rtl/math_op_arbiter.sv
// Two-requester round-robin front end for one shared math_operators unit.
//   clk, reset                : clock, asynchronous active-high reset
//   reqN_valid/ready          : request handshake for requester N (0/1)
//   reqN_op, reqN_a, reqN_b   : operation code and operands
//   rsp_valid/ready           : response handshake (single-entry register)
//   rsp_id                    : requester that issued the held result
//   rsp_result                : 2*WIDTH result (add/sub zero-extended)
//   rsp_err                   : held result came from a reserved opcode
module math_op_arbiter
  import math_op_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               req0_valid,
  output logic               req0_ready,
  input  op_t                req0_op,
  input  logic [WIDTH-1:0]   req0_a,
  input  logic [WIDTH-1:0]   req0_b,
  input  logic               req1_valid,
  output logic               req1_ready,
  input  op_t                req1_op,
  input  logic [WIDTH-1:0]   req1_a,
  input  logic [WIDTH-1:0]   req1_b,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic               rsp_id,
  output logic [2*WIDTH-1:0] rsp_result,
  output logic               rsp_err
);

  function automatic logic [2*WIDTH-1:0] select_result(
    input op_t                op,
    input logic [WIDTH-1:0]   s,
    input logic [WIDTH-1:0]   d,
    input logic [2*WIDTH-1:0] p
  );
    logic [2*WIDTH-1:0] r;
    case (op)
      OP_ADD:  r = {{WIDTH{1'b0}}, s};
      OP_SUB:  r = {{WIDTH{1'b0}}, d};
      OP_MUL:  r = p;
      default: r = '0;
    endcase
    return r;
  endfunction

  slot_state_t        state_q, state_d;
  logic               last_grant_q;
  logic               slot_free;
  logic               winner_p0;
  logic               accept_p0;
  op_t                op_p0;
  logic [WIDTH-1:0]   a_p0;
  logic [WIDTH-1:0]   b_p0;
  logic [WIDTH-1:0]   s_p0;
  logic [WIDTH-1:0]   d_p0;
  logic [2*WIDTH-1:0] p_p0;
  logic [2*WIDTH-1:0] res_p0;
  logic               err_p0;

  logic               vld_p1;
  logic               id_p1;
  logic [2*WIDTH-1:0] res_p1;
  logic               err_p1;

  // ---- stage p0: arbitration, operand mux, shared datapath ----
  always_comb begin
    state_d   = state_q;
    slot_free = (state_q == EMPTY) || rsp_ready;
    // On a tie the requester that did not win last time goes next.
    if (req0_valid && req1_valid) winner_p0 = ~last_grant_q;
    else                          winner_p0 = req1_valid;
    accept_p0  = slot_free && (req0_valid || req1_valid);
    req0_ready = slot_free && !winner_p0 && req0_valid;
    req1_ready = slot_free &&  winner_p0 && req1_valid;
    case (state_q)
      EMPTY:   if (accept_p0) state_d = FULL;
      FULL:    if (rsp_ready && !accept_p0) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  assign op_p0 = winner_p0 ? req1_op : req0_op;
  assign a_p0  = winner_p0 ? req1_a  : req0_a;
  assign b_p0  = winner_p0 ? req1_b  : req0_b;

  math_operators #(.WIDTH(WIDTH)) u_ops (
    .a (a_p0),
    .b (b_p0),
    .s (s_p0),
    .d (d_p0),
    .p (p_p0)
  );

  assign res_p0 = select_result(op_p0, s_p0, d_p0, p_p0);
  assign err_p0 = (op_p0 == OP_RSV);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= EMPTY;
      last_grant_q <= 1'b1;
    end else begin
      state_q <= state_d;
      if (accept_p0) last_grant_q <= winner_p0;
    end
  end

  // ---- stage p1: response register ----
  // Reset clears the payload too so a discarded result never reappears.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      id_p1  <= 1'b0;
      res_p1 <= '0;
      err_p1 <= 1'b0;
    end else if (accept_p0) begin
      id_p1  <= winner_p0;
      res_p1 <= res_p0;
      err_p1 <= err_p0;
    end
  end

  assign vld_p1     = (state_q == FULL);
  assign rsp_valid  = vld_p1;
  assign rsp_id     = id_p1;
  assign rsp_result = res_p1;
  assign rsp_err    = err_p1;

endmodule

// File: tb/tb_math_op_arbiter.sv
module tb_math_op_arbiter;
  import math_op_pkg::*;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset;
  logic             req0_valid, req0_ready;
  op_t              req0_op;
  logic [WIDTH-1:0] req0_a, req0_b;
  logic             req1_valid, req1_ready;
  op_t              req1_op;
  logic [WIDTH-1:0] req1_a, req1_b;
  logic             rsp_valid, rsp_ready, rsp_id, rsp_err;
  logic [2*WIDTH-1:0] rsp_result;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  math_op_arbiter #(.WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_op    (req0_op),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_op    (req1_op),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_id     (rsp_id),
    .rsp_result (rsp_result),
    .rsp_err    (rsp_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rsp(input string tag, input logic v, input logic id,
                     input logic [7:0] res, input logic err);
    check({tag, "_valid"},  {31'd0, rsp_valid}, {31'd0, v});
    check({tag, "_id"},     {31'd0, rsp_id},    {31'd0, id});
    check({tag, "_result"}, {24'd0, rsp_result}, {24'd0, res});
    check({tag, "_err"},    {31'd0, rsp_err},   {31'd0, err});
  endtask

  task automatic rdy(input string tag, input logic r0, input logic r1);
    check({tag, "_ready0"}, {31'd0, req0_ready}, {31'd0, r0});
    check({tag, "_ready1"}, {31'd0, req1_ready}, {31'd0, r1});
  endtask

  initial begin
    // Reset with both requests pending
    reset = 1'b1; rsp_ready = 1'b1;
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 4'd7; req0_b = 4'd5;
    req1_valid = 1'b1; req1_op = OP_SUB; req1_a = 4'd3; req1_b = 4'd5;
    tick(); tick();
    rsp("reset", 1'b0, 1'b0, 8'h00, 1'b0);
    rdy("reset", 1'b1, 1'b0);
    reset = 1'b0;
    #1;
    rdy("first_tie", 1'b1, 1'b0);

    // Single add from req0 (tie won by 0)
    tick();
    rsp("add", 1'b1, 1'b0, 8'h0C, 1'b0);
    req0_valid = 1'b0;
    #1;
    rdy("req1_alone", 1'b0, 1'b1);

    // Subtract wrap from req1
    tick();
    rsp("sub", 1'b1, 1'b1, 8'h0E, 1'b0);

    // Full multiply from req1
    req1_op = OP_MUL; req1_a = 4'hF; req1_b = 4'hF;
    tick();
    rsp("mul", 1'b1, 1'b1, 8'hE1, 1'b0);
    req1_valid = 1'b0;
    tick();
    check("drain_empty", {31'd0, rsp_valid}, 32'd0);

    // Fair tie for four cycles, no bubbles
    req0_valid = 1'b1; req0_op = OP_ADD; req0_a = 4'd1; req0_b = 4'd2;
    req1_valid = 1'b1; req1_op = OP_ADD; req1_a = 4'd3; req1_b = 4'd4;
    tick();
    rsp("tie0", 1'b1, 1'b0, 8'h03, 1'b0);
    req0_a = 4'd5; req0_b = 4'd6;
    tick();
    rsp("tie1", 1'b1, 1'b1, 8'h07, 1'b0);
    req1_a = 4'd8; req1_b = 4'd8;
    tick();
    rsp("tie2", 1'b1, 1'b0, 8'h0B, 1'b0);
    req0_op = OP_SUB; req0_a = 4'd2; req0_b = 4'd1;
    tick();
    rsp("tie3", 1'b1, 1'b1, 8'h00, 1'b0);

    // Backpressure: hold for three cycles with req0 pending
    req1_valid = 1'b0; rsp_ready = 1'b0;
    #1;
    rdy("bp_start", 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      rsp("bp_hold", 1'b1, 1'b1, 8'h00, 1'b0);
      rdy("bp_hold", 1'b0, 1'b0);
    end
    rsp_ready = 1'b1;
    #1;
    rdy("bp_release", 1'b1, 1'b0);
    tick();
    rsp("bp_new", 1'b1, 1'b0, 8'h01, 1'b0);
    req0_valid = 1'b0;
    tick();
    check("bp_drain", {31'd0, rsp_valid}, 32'd0);

    // Reserved opcode
    req0_valid = 1'b1; req0_op = OP_RSV; req0_a = 4'd5; req0_b = 4'd3;
    tick();
    rsp("rsv", 1'b1, 1'b0, 8'h00, 1'b1);

    // Hold a result, then reset mid-operation
    req0_valid = 1'b0; rsp_ready = 1'b0;
    req1_valid = 1'b1; req1_op = OP_MUL; req1_a = 4'd3; req1_b = 4'd5;
    rsp_ready = 1'b1;
    tick();
    rsp("pre_reset", 1'b1, 1'b1, 8'h0F, 1'b0);
    req1_valid = 1'b0; rsp_ready = 1'b0;
    tick();
    rsp("held", 1'b1, 1'b1, 8'h0F, 1'b0);
    reset = 1'b1;
    #1;
    rsp("mid_reset", 1'b0, 1'b0, 8'h00, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    check("after_reset", {31'd0, rsp_valid}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
